// File: rtl/hex_viewer_pkg.sv
// Shared constants and the hex-to-seven-segment decoder for the multi-digit hex viewer.
// Segments are active-low and ordered {g,f,e,d,c,b,a}.
package hex_viewer_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [2:0] ANIM_LAST = 3'd6;

    // Segment reveal sequence for animation steps 0..5; step 6 shows the decoded value.
    localparam logic [6:0] REVEAL_PAT [0:5] = '{7'h7F, 7'h7E, 7'h7C, 7'h78, 7'h70, 7'h60};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ANIM = 1'b1
    } anim_state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_digit_anim.sv
// One display digit: latches its nibble, runs the 7-step change animation and
// selects the segment pattern for the current step (unregistered; the top registers it).
module hex_digit_anim
    import hex_viewer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] nibble_sync,
    input  logic       tick,
    input  logic       mode_blink,
    output logic [6:0] seg,
    output logic       active,
    output logic [3:0] latched
);

    anim_state_e state_r, state_s;
    logic [2:0]  step_r, step_s;
    logic [3:0]  latch_r, latch_s;
    logic [6:0]  value_seg_s;
    logic [6:0]  seg_s;

    // State, step counter and latched nibble registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            step_r  <= 3'd0;
            latch_r <= 4'd0;
        end else begin
            state_r <= state_s;
            step_r  <= step_s;
            latch_r <= latch_s;
        end
    end

    // Next state: a nibble change restarts the animation and beats a same-cycle tick.
    always_comb begin
        state_s = state_r;
        step_s  = step_r;
        latch_s = latch_r;
        if (nibble_sync != latch_r) begin
            latch_s = nibble_sync;
            step_s  = 3'd0;
            state_s = ST_ANIM;
        end else if ((state_r == ST_ANIM) && tick) begin
            if (step_r < ANIM_LAST) begin
                step_s = step_r + 3'd1;
            end else begin
                step_s  = 3'd0;
                state_s = ST_IDLE;
            end
        end else begin
            state_s = state_r;
        end
    end

    // Segment pattern for the current state; mode_blink only changes how a step renders.
    always_comb begin
        value_seg_s = hex_to_seg(latch_r);
        seg_s       = value_seg_s;
        if (state_r == ST_ANIM) begin
            if (mode_blink) begin
                seg_s = step_r[0] ? value_seg_s : SEG_BLANK;
            end else begin
                case (step_r)
                    3'd0:    seg_s = REVEAL_PAT[0];
                    3'd1:    seg_s = REVEAL_PAT[1];
                    3'd2:    seg_s = REVEAL_PAT[2];
                    3'd3:    seg_s = REVEAL_PAT[3];
                    3'd4:    seg_s = REVEAL_PAT[4];
                    3'd5:    seg_s = REVEAL_PAT[5];
                    default: seg_s = value_seg_s;
                endcase
            end
        end else begin
            seg_s = value_seg_s;
        end
    end

    assign seg     = seg_s;
    assign active  = (state_r == ST_ANIM);
    assign latched = latch_r;

endmodule

// File: rtl/multi_hex_viewer.sv
// N-digit hex viewer: synchronises the switch value, shares one step divider across
// all digit animators, applies leading-zero blanking and registers hex_out and busy.
module multi_hex_viewer
    import hex_viewer_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int CLK_HZ   = 50_000_000,
    parameter int FAST_HZ  = 10,
    parameter int SLOW_HZ  = 2
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic                  speed_fast,
    input  logic                  mode_blink,
    input  logic                  lz_blank,
    output logic [7*N_DIGITS-1:0] hex_out,
    output logic                  busy
);

    localparam int DIV_W = $clog2(CLK_HZ / SLOW_HZ);
    localparam logic [DIV_W-1:0] LIMIT_FAST = DIV_W'(CLK_HZ / FAST_HZ - 1);
    localparam logic [DIV_W-1:0] LIMIT_SLOW = DIV_W'(CLK_HZ / SLOW_HZ - 1);

    logic [4*N_DIGITS-1:0] sync1_r, sync2_r;
    logic [DIV_W-1:0]      cnt_r;
    logic [DIV_W-1:0]      limit_s;
    logic                  tick_s;
    logic [6:0]            seg_s     [N_DIGITS];
    logic [3:0]            latched_s [N_DIGITS];
    logic [N_DIGITS-1:0]   active_s;
    logic [N_DIGITS-1:0]   blank_s;
    logic [7*N_DIGITS-1:0] hex_nxt_s;
    logic [7*N_DIGITS-1:0] hex_out_r;
    logic                  busy_r;

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_r <= {(4*N_DIGITS){1'b0}};
            sync2_r <= {(4*N_DIGITS){1'b0}};
        end else begin
            sync1_r <= value_in;
            sync2_r <= sync1_r;
        end
    end

    // A >= compare lets a mid-count speed change produce the next tick within one cycle.
    assign limit_s = speed_fast ? LIMIT_FAST : LIMIT_SLOW;
    assign tick_s  = (cnt_r >= limit_s);

    // Shared animation step divider.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {DIV_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + DIV_W'(1);
        end
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
        hex_digit_anim u_digit (
            .clk         (CLOCK_50),
            .rst_n       (RESET_N),
            .nibble_sync (sync2_r[4*g +: 4]),
            .tick        (tick_s),
            .mode_blink  (mode_blink),
            .seg         (seg_s[g]),
            .active      (active_s[g]),
            .latched     (latched_s[g])
        );
    end

    // Leading-zero blanking: scan from the top digit while every nibble so far is zero.
    always_comb begin
        logic higher_zero;
        blank_s     = {N_DIGITS{1'b0}};
        hex_nxt_s   = {(7*N_DIGITS){1'b1}};
        higher_zero = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero & (latched_s[i] == 4'd0);
            blank_s[i]  = lz_blank & (i != 0) & higher_zero & ~active_s[i];
            hex_nxt_s[7*i +: 7] = blank_s[i] ? SEG_BLANK : seg_s[i];
        end
    end

    // Output registers; reset shows all digits blank.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            hex_out_r <= {(7*N_DIGITS){1'b1}};
            busy_r    <= 1'b0;
        end else begin
            hex_out_r <= hex_nxt_s;
            busy_r    <= |active_s;
        end
    end

    assign hex_out = hex_out_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_multi_hex_viewer.sv
// Directed self-checking bench for multi_hex_viewer with a 100 Hz "clock" so that
// fast steps are 10 cycles and slow steps are 50 cycles.
module tb_multi_hex_viewer;

    localparam logic [6:0] REV_A [6] = '{7'h7E, 7'h7C, 7'h78, 7'h70, 7'h60, 7'h08};
    localparam logic [6:0] REV_B [6] = '{7'h7E, 7'h7C, 7'h78, 7'h70, 7'h60, 7'h03};
    localparam logic [6:0] BLINK5 [7] = '{7'h12, 7'h7F, 7'h12, 7'h7F, 7'h12, 7'h7F, 7'h12};

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N;
    logic [15:0] value_in;
    logic        speed_fast;
    logic        mode_blink;
    logic        lz_blank;
    logic [27:0] hex_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    multi_hex_viewer #(
        .N_DIGITS (4),
        .CLK_HZ   (100),
        .FAST_HZ  (10),
        .SLOW_HZ  (2)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .RESET_N    (RESET_N),
        .value_in   (value_in),
        .speed_fast (speed_fast),
        .mode_blink (mode_blink),
        .lz_blank   (lz_blank),
        .hex_out    (hex_out),
        .busy       (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] dig(input int d);
        return hex_out[7*d +: 7];
    endfunction

    // Wait (bounded) for digit d to change; n = negedges waited.
    task automatic wait_dig(input int d, input int limit, output logic [6:0] val, output int n);
        logic [6:0] old;
        old = dig(d);
        n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while ((dig(d) === old) && (n < limit));
        val = dig(d);
    endtask

    task automatic wait_busy(input logic lvl, input int limit, output int n);
        n = 0;
        while ((busy !== lvl) && (n < limit)) begin
            @(negedge CLOCK_50);
            n++;
        end
    endtask

    initial begin
        logic [6:0] v;
        int n;
        int busy_seen;

        RESET_N    = 1'b0;
        value_in   = 16'h0000;
        speed_fast = 1'b1;
        mode_blink = 1'b0;
        lz_blank   = 1'b0;

        // 1: reset state and first display
        repeat (3) @(negedge CLOCK_50);
        check("rst_hex", hex_out, {4{7'h7F}});
        check("rst_busy", busy, 1'b0);
        RESET_N = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        check("init_hex", hex_out, {4{7'h40}});
        check("init_busy", busy, 1'b0);

        // 2: fast reveal of A on digit 1
        value_in = 16'h00A0;
        wait_dig(1, 20, v, n);
        check("t2_first", v, 7'h7F);
        check("t2_latency", n, 4);
        check("t2_busy_on", busy, 1'b1);
        for (int k = 0; k < 6; k++) begin
            wait_dig(1, 20, v, n);
            check("t2_step", v, REV_A[k]);
            if (k > 0) check("t2_period", n, 10);
        end
        check("t2_busy_last", busy, 1'b1);
        check("t2_others", {hex_out[27:14], hex_out[6:0]}, {3{7'h40}});
        wait_busy(1'b0, 20, n);
        check("t2_busy_off", busy, 1'b0);
        check("t2_tail", n, 10);
        check("t2_final", dig(1), 7'h08);

        // 3: retrigger at step 3, then retrigger coincident with a tick
        value_in = 16'h0000;
        wait_busy(1'b1, 10, n);
        wait_busy(1'b0, 100, n);
        value_in = 16'h00A0;
        for (int k = 0; k < 4; k++) wait_dig(1, 20, v, n);
        check("t3_step3", v, 7'h78);
        value_in = 16'h00B0;
        wait_dig(1, 20, v, n);
        check("t3_restart", v, 7'h7F);
        check("t3_restart_lat", n, 4);
        for (int k = 0; k < 6; k++) begin
            wait_dig(1, 20, v, n);
            check("t3_step", v, REV_B[k]);
        end
        wait_busy(1'b0, 20, n);
        check("t3_final", dig(1), 7'h03);
        check("t3_busy_off", busy, 1'b0);

        value_in = 16'h00C0;
        for (int k = 0; k < 3; k++) wait_dig(1, 20, v, n);
        check("t3_c_step2", v, 7'h7C);
        // tick that produced 7C came one edge before this sample; next tick lands 9 edges on,
        // which is the edge where a change applied now gets latched
        repeat (6) @(negedge CLOCK_50);
        value_in = 16'h00D0;
        wait_dig(1, 20, v, n);
        check("t3_tie_restart", v, 7'h7F);
        check("t3_tie_lat", n, 4);
        wait_dig(1, 20, v, n);
        check("t3_tie_step1", v, 7'h7E);
        check("t3_tie_period", n, 10);
        wait_busy(1'b0, 100, n);
        check("t3_tie_final", dig(1), 7'h21);

        // 4: slow blink of 5 on digit 0
        value_in = 16'h0000;
        wait_busy(1'b1, 10, n);
        wait_busy(1'b0, 100, n);
        speed_fast = 1'b0;
        mode_blink = 1'b1;
        value_in   = 16'h0005;
        wait_dig(0, 20, v, n);
        check("t4_first", v, 7'h7F);
        check("t4_latency", n, 4);
        for (int k = 0; k < 7; k++) begin
            wait_dig(0, 60, v, n);
            check("t4_step", v, BLINK5[k]);
            if (k > 0) check("t4_period", n, 50);
        end
        check("t4_busy_off", busy, 1'b0);

        // 5: leading-zero blanking
        speed_fast = 1'b1;
        mode_blink = 1'b0;
        lz_blank   = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        check("t5_lz_0005", hex_out, {7'h7F, 7'h7F, 7'h7F, 7'h12});
        value_in = 16'h0050;
        wait_busy(1'b1, 10, n);
        wait_busy(1'b0, 100, n);
        check("t5_lz_0050", hex_out, {7'h7F, 7'h7F, 7'h12, 7'h40});
        value_in = 16'h0000;
        wait_busy(1'b1, 10, n);
        wait_busy(1'b0, 100, n);
        check("t5_lz_0000", hex_out, {7'h7F, 7'h7F, 7'h7F, 7'h40});

        // 6: asynchronous reset mid-animation
        lz_blank = 1'b0;
        value_in = 16'h00A0;
        wait_busy(1'b1, 10, n);
        check("t6_busy_on", busy, 1'b1);
        repeat (15) @(negedge CLOCK_50);
        #2;
        RESET_N  = 1'b0;
        value_in = 16'h0000;
        #1;
        check("t6_rst_hex", hex_out, {4{7'h7F}});
        check("t6_rst_busy", busy, 1'b0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (6) @(negedge CLOCK_50);
        check("t6_post_hex", hex_out, {4{7'h40}});
        busy_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge CLOCK_50);
            if (busy !== 1'b0) busy_seen++;
        end
        check("t6_no_anim", busy_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
